bcd_serial_addsub: RTL and testbench

//   Digit-serial packed-BCD add/subtract stage. Accepts two DIGITS-wide packed
//   BCD operands over a valid/ready handshake and processes one digit per

---
 rtl/bcd_serial_addsub_if.sv | 26 ++
 rtl/bcd_serial_addsub.sv | 134 +++++++++++++
 tb/tb_bcd_serial_addsub.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bcd_serial_addsub_if.sv
// Handshake bundle for the digit-serial BCD add/sub stage: operand set in, packed result out.
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_a;
  logic [4*DIGITS-1:0]   in_b;
  logic                  in_sub;
  logic                  in_cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_res;
  logic                  out_cout;
  logic                  out_err;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_res, out_cout, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_res, out_cout, out_err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD add/subtract, LSD first, one digit per cycle with a rippled carry/borrow.
// Latency DIGITS cycles accept->out_valid; in_ready only in IDLE, result held until out_ready.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_serial_addsub_if.slave     bus
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    res_q, res_d, out_res_q, out_res_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            sub_q, sub_d, carry_q, carry_d, err_q, err_d;
  logic            out_cout_q, out_cout_d, out_err_q, out_err_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [3:0]      da, db, digit;
  logic [4:0]      sum5, dif5;
  logic            carry_nxt, err_nxt, last;
  logic [W-1:0]    res_nxt;

  // Digit datapath: the operands shift right so the active digit is always in [3:0].
  always_comb begin
    da   = a_q[3:0];
    db   = b_q[3:0];
    sum5 = {1'b0, da} + {1'b0, db} + {4'b0, carry_q};
    dif5 = {1'b0, da} - {1'b0, db} - {4'b0, carry_q};
    if (sub_q) begin
      carry_nxt = dif5[4];
      digit     = carry_nxt ? (dif5[3:0] + 4'd10) : dif5[3:0];
    end else begin
      carry_nxt = (sum5 > 5'd9);
      digit     = carry_nxt ? (sum5[3:0] - 4'd10) : sum5[3:0];
    end
    res_nxt = res_q;
    res_nxt[{idx_q, 2'b00} +: 4] = digit;
    err_nxt = err_q | (da > 4'd9) | (db > 4'd9);
    last    = (idx_q == IW'(DIGITS - 1));
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    idx_d      = idx_q;
    sub_d      = sub_q;
    carry_d    = carry_q;
    err_d      = err_q;
    out_res_d  = out_res_q;
    out_cout_d = out_cout_q;
    out_err_d  = out_err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          sub_d   = bus.in_sub;
          carry_d = bus.in_cin;
          idx_d   = '0;
          err_d   = 1'b0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = carry_nxt;
        res_d   = res_nxt;
        err_d   = err_nxt;
        if (last) begin
          state_d    = DONE;
          out_res_d  = res_nxt;
          out_cout_d = carry_nxt;
          out_err_d  = err_nxt;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        // No bypass: IDLE must be visited for a cycle before the next accept.
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      out_res_q   <= '0;
      out_cout_q  <= 1'b0;
      out_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      idx_q       <= idx_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      out_res_q   <= out_res_d;
      out_cout_q  <= out_cout_d;
      out_err_q   <= out_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed-vector bench for bcd_serial_addsub (DIGITS=4) with hand-computed expected results.
module tb_bcd_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub_if #(.DIGITS(4)) bus ();

  bcd_serial_addsub #(.DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin, input string tag);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_cin   = cin;
    chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = 16'hFFFF;
    bus.in_b     = 16'hFFFF;
    bus.in_sub   = ~sub;
    bus.in_cin   = ~cin;
  endtask

  // Called #1 after the accept edge; counts edges until out_valid rises.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, 32'd4);
  endtask

  task automatic check_res(input string tag, input logic [15:0] res,
                           input logic cout, input logic err);
    chk({tag, "_res"},  {16'b0, bus.out_res}, {16'b0, res});
    chk({tag, "_cout"}, {31'b0, bus.out_cout}, {31'b0, cout});
    chk({tag, "_err"},  {31'b0, bus.out_err}, {31'b0, err});
  endtask

  task automatic release_res(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_idle"}, {30'b0, bus.in_ready, bus.out_valid}, 32'b10);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic cin, input logic [15:0] res, input logic cout,
                        input logic err, input string tag);
    start_op(a, b, sub, cin, tag);
    wait_done(tag);
    check_res(tag, res, cout, err);
    release_res(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_res("rst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    run_op(16'h0999, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "add_ripple");
    run_op(16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "add_cin");
    run_op(16'h0100, 16'h0001, 1'b1, 1'b0, 16'h0099, 1'b0, 1'b0, "sub_borrow");
    run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, "sub_wrap");
    run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, "add_bad_digit");
    run_op(16'h1234, 16'h0567, 1'b1, 1'b1, 16'h0666, 1'b0, 1'b0, "sub_bin");

    // Result held under backpressure, then a set offered together with out_ready.
    start_op(16'h4567, 16'h5678, 1'b0, 1'b0, "hold");
    wait_done("hold");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_stable", {12'b0, bus.in_ready, bus.out_valid, bus.out_cout, bus.out_err, bus.out_res},
          {12'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0245});
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'h1234;
    bus.in_b      = 16'h0567;
    bus.in_sub    = 1'b1;
    bus.in_cin    = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("nobypass_idle", {30'b0, bus.in_ready, bus.out_valid}, 32'b10);
    chk("nobypass_keep", {16'b0, bus.out_res}, 32'h0245);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("next_accepted", {31'b0, bus.in_ready}, 32'd0);
    wait_done("next");
    check_res("next", 16'h0666, 1'b0, 1'b0);
    release_res("next");

    // Abort mid-RUN.
    start_op(16'h0999, 16'h0001, 1'b0, 1'b0, "abort");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_res("abort", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_valid", {31'b0, bus.out_valid}, 32'd0);
    run_op(16'h4567, 16'h5678, 1'b0, 1'b0, 16'h0245, 1'b1, 1'b0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
